// File: rtl/rtp_rx_depack.sv
// RTP/UDP receive depacketiser: validates the RTP header and SSRC of each datagram,
// unpacks big-endian 16-bit samples into a FIFO and serves them one per playback request.
module rtp_rx_depack #(
  parameter logic [15:0] RTP_HEADER_PARAM = 16'h8080,
  parameter logic [31:0] SSRC             = 32'h12345678,
  parameter int          FIFO_AW          = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_drop_cnt,
  output logic [15:0]        seq_err_cnt,
  output logic [15:0]        ovf_cnt,
  output logic [15:0]        unf_cnt,
  output logic [2:0]         o_dbg_state
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = DEPTH[FIFO_AW:0];

  // Input handshake: a byte is consumed on every rising edge where udp_rec_data_valid
  // is high; valid is never back-pressured. A cycle with valid low after any byte
  // ends the datagram. wav_rden is a one-cycle request with no ready; it is always served.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DROP    = 3'd3,
    S_TAIL    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_bidx;
  logic [15:0]        w_bidx_nxt;
  logic [15:0]        w_idx;
  logic               w_hdr_ok;
  logic               w_ok_inc;
  logic               w_drop_inc;
  logic               w_accept;
  logic               w_hi_ld;
  logic               w_wr;
  logic [15:0]        r_seq;
  logic [15:0]        r_last_seq;
  logic               r_have_prev;
  logic [7:0]         r_hi;
  logic [15:0]        w_sample;

  logic [15:0]        r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_do;
  logic               w_ovf;
  logic               w_rd_do;
  logic               w_unf;

  assign o_dbg_state = r_state;
  assign fifo_level  = r_level;
  assign w_sample    = {r_hi, udp_rec_rdata};

  // Byte 0 arrives while still in IDLE, so its index is forced to zero there.
  assign w_idx = (r_state == S_IDLE) ? 16'd0 : r_bidx;

  always_comb begin
    w_hdr_ok = 1'b1;
    case (w_idx)
      16'd0:   w_hdr_ok = (udp_rec_rdata == RTP_HEADER_PARAM[15:8]) &&
                          (udp_rec_data_length >= 16'd12) && !udp_rec_data_length[0];
      16'd1:   w_hdr_ok = (udp_rec_rdata[6:0] == RTP_HEADER_PARAM[6:0]);
      16'd8:   w_hdr_ok = (udp_rec_rdata == SSRC[31:24]);
      16'd9:   w_hdr_ok = (udp_rec_rdata == SSRC[23:16]);
      16'd10:  w_hdr_ok = (udp_rec_rdata == SSRC[15:8]);
      16'd11:  w_hdr_ok = (udp_rec_rdata == SSRC[7:0]);
      default: w_hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bidx_nxt  = r_bidx;
    w_ok_inc    = 1'b0;
    w_drop_inc  = 1'b0;
    w_accept    = 1'b0;
    w_hi_ld     = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bidx_nxt = 16'd0;
        if (udp_rec_data_valid) begin
          w_bidx_nxt  = 16'd1;
          w_state_nxt = w_hdr_ok ? S_HDR : S_DROP;
        end
      end
      S_HDR: begin
        if (!udp_rec_data_valid) begin
          w_drop_inc  = 1'b1;
          w_bidx_nxt  = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_bidx_nxt = r_bidx + 16'd1;
          if (!w_hdr_ok) begin
            w_state_nxt = S_DROP;
          end else if (r_bidx == 16'd11) begin
            w_accept    = 1'b1;
            w_state_nxt = (udp_rec_data_length == 16'd12) ? S_TAIL : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          w_drop_inc  = 1'b1;
          w_bidx_nxt  = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_bidx_nxt = r_bidx + 16'd1;
          // Payload starts at the even index 12, so bidx parity gives the byte's role.
          if (!r_bidx[0]) w_hi_ld = 1'b1;
          else            w_wr    = 1'b1;
          if (r_bidx == udp_rec_data_length - 16'd1) w_state_nxt = S_TAIL;
        end
      end
      S_DROP: begin
        if (!udp_rec_data_valid) begin
          w_drop_inc  = 1'b1;
          w_bidx_nxt  = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_bidx_nxt = r_bidx + 16'd1;
        end
      end
      S_TAIL: begin
        if (!udp_rec_data_valid) begin
          w_ok_inc    = 1'b1;
          w_bidx_nxt  = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_bidx_nxt = r_bidx + 16'd1;
        end
      end
      default: begin
        w_bidx_nxt  = 16'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bidx       <= 16'd0;
      r_seq        <= 16'd0;
      r_last_seq   <= 16'd0;
      r_have_prev  <= 1'b0;
      r_hi         <= 8'd0;
      pkt_ok_cnt   <= 16'd0;
      pkt_drop_cnt <= 16'd0;
      seq_err_cnt  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_bidx  <= w_bidx_nxt;
      if (r_state == S_HDR && udp_rec_data_valid) begin
        if (r_bidx == 16'd2) r_seq[15:8] <= udp_rec_rdata;
        if (r_bidx == 16'd3) r_seq[7:0]  <= udp_rec_rdata;
      end
      if (w_accept) begin
        if (r_have_prev && (r_seq != r_last_seq + 16'd1)) seq_err_cnt <= seq_err_cnt + 16'd1;
        r_last_seq  <= r_seq;
        r_have_prev <= 1'b1;
      end
      if (w_hi_ld)    r_hi         <= udp_rec_rdata;
      if (w_ok_inc)   pkt_ok_cnt   <= pkt_ok_cnt + 16'd1;
      if (w_drop_inc) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
    end
  end

  // Fullness and emptiness use the level at the start of the cycle: a same-cycle
  // read neither makes room for a write nor can return the word being written.
  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_wr_do = w_wr && !w_full;
  assign w_ovf   = w_wr && w_full;
  assign w_rd_do = wav_rden && !w_empty;
  assign w_unf   = wav_rden && w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_do) r_mem[r_wptr] <= w_sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      wav_out_data <= 16'd0;
      ovf_cnt      <= 16'd0;
      unf_cnt      <= 16'd0;
    end else begin
      if (w_wr_do) r_wptr <= r_wptr + 1'b1;
      if (w_rd_do) begin
        wav_out_data <= r_mem[r_rptr];
        r_rptr       <= r_rptr + 1'b1;
      end else if (w_unf) begin
        wav_out_data <= 16'd0;
      end
      case ({w_wr_do, w_rd_do})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ovf) ovf_cnt <= ovf_cnt + 16'd1;
      if (w_unf) unf_cnt <= unf_cnt + 16'd1;
    end
  end

endmodule

// File: doc/rtp_rx_depack.md
RTP_RX_DEPACK -- requirements
Module: rtp_rx_depack

Interface
REQ-001 SHALL have parameter RTP_HEADER_PARAM, default 16'h8080, expected RTP bytes 0-1 with the M bit excluded from comparison.
REQ-002 SHALL have parameter SSRC, default 32'h12345678, the only accepted stream source.
REQ-003 SHALL have parameter FIFO_AW, default 10, sample FIFO depth = 2^FIFO_AW 16-bit words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port udp_rec_data_valid, input, 1 bit: high for each received UDP payload byte; contiguous per datagram; a falling edge marks the datagram end.
REQ-007 SHALL have port udp_rec_rdata, input, 8 bits: payload byte, qualified by udp_rec_data_valid.
REQ-008 SHALL have port udp_rec_data_length, input, 16 bits: UDP payload byte count, stable while valid is high.
REQ-009 SHALL have port wav_rden, input, 1 bit: one-cycle playback sample request.
REQ-010 SHALL have port wav_out_data, output, 16 bits: registered playback sample.
REQ-011 SHALL have port fifo_level, output, FIFO_AW+1 bits: current number of stored samples.
REQ-012 SHALL have ports pkt_ok_cnt, pkt_drop_cnt, seq_err_cnt, ovf_cnt and unf_cnt, each output, 16 bits: wrapping event counters.

Function
REQ-013 SHALL implement the states IDLE, HDR, PAYLOAD, DROP and TAIL, with a byte index counter bidx (16 bits) that counts from 0 within each datagram.
REQ-014 SHALL move from IDLE to HDR on the first valid byte, which is byte 0 (bidx=0); that byte is also checked.
REQ-015 SHALL apply HDR checks on the fly: byte0 == RTP_HEADER_PARAM[15:8]; byte1[6:0] == RTP_HEADER_PARAM[6:0]; bytes 8-11 == SSRC, big-endian; length >= 12; (length-12) even.
REQ-016 SHALL enter DROP on any failed check; DROP consumes bytes until valid falls, then increments pkt_drop_cnt and returns to IDLE.
REQ-017 SHALL capture the sequence number from bytes 2-3 (big-endian) and compare it after byte 11 passes: if a previous packet was accepted and seq != last_seq+1 (mod 2^16), seq_err_cnt increments; the packet is still accepted; last_seq <= seq.
REQ-018 SHALL, after byte 11 passes, enter PAYLOAD if length > 12; if length == 12, it SHALL enter TAIL with no samples written.
REQ-019 SHALL, in PAYLOAD, treat even payload bytes as the sample high byte and odd payload bytes as the low byte; the FIFO write occurs on the cycle the low byte is valid.
REQ-020 SHALL discard a sample and increment ovf_cnt if a write finds the FIFO full; the read pointer is untouched.
REQ-021 SHALL leave PAYLOAD for TAIL after byte length-1.
REQ-022 SHALL ignore any bytes beyond length in TAIL; when valid falls, pkt_ok_cnt increments and the state returns to IDLE.
REQ-023 SHALL handle valid falling before byte length-1 while in HDR or PAYLOAD as a truncation: pkt_drop_cnt increments; samples already written stay in the FIFO; any pending high byte is discarded; last_seq is not updated if truncated in HDR.
REQ-024 SHALL, on wav_rden with the FIFO non-empty, load wav_out_data with the head sample on the next clock edge and pop it.
REQ-025 SHALL, on wav_rden with the FIFO empty, load wav_out_data with 16'h0000 and increment unf_cnt.
REQ-026 SHALL leave wav_out_data holding its value when wav_rden is low.
REQ-027 SHALL, on a same-cycle write and read, perform both; fifo_level is unchanged; an empty FIFO with a same-cycle write still underruns (no write-through).
REQ-028 SHALL wrap the FIFO pointers modulo 2^FIFO_AW; fifo_level SHALL range from 0 to 2^FIFO_AW inclusive.
REQ-029 SHALL not depend on udp_rec_data_length when valid is low.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously clear: state=IDLE, bidx=0, FIFO pointers=0, fifo_level=0, wav_out_data=0, all counters=0, the "previous packet accepted" flag=0, last_seq=0.
REQ-031 SHALL, when reset is asserted mid-datagram, discard the remainder; after release, the FSM waits in IDLE; if valid is still high, the ongoing bytes SHALL be parsed as a new datagram starting at byte 0.

Verification
REQ-032 SHALL verify: datagram of length 16, header 80 00 00 05 ts[4] 12 34 56 78, payload AB CD 01 02 -> fifo_level=2, pkt_ok_cnt=1; two wav_rden pulses -> wav_out_data 16'hABCD then 16'h0102.
REQ-033 SHALL verify: same packet with byte 9 = 8'h35 -> no FIFO writes, pkt_drop_cnt=1, fifo_level=0.
REQ-034 SHALL verify: seq 5 then seq 7, both valid -> seq_err_cnt=1, pkt_ok_cnt=2, all 4 samples stored.
REQ-035 SHALL verify: FIFO_AW=2 with a 6-sample packet (length 24) -> fifo_level=4, ovf_cnt=2; 5 reads -> the first 4 samples, then 16'h0000 with unf_cnt=1.
REQ-036 SHALL verify: length 16 but valid falls after 14 bytes -> first sample stored, pkt_drop_cnt=1; next valid packet accepted normally.
REQ-037 SHALL verify: rst_n pulsed low mid-payload -> all outputs 0 immediately; a following clean packet parses correctly.
